mem_ctrl: RTL and testbench

- Sequences the CPU's single byte-wide RAM port and shares it between instruction fetch (IF) and the memory stage (MEM).
- Turns 32-bit fetch, load and store requests into byte-serial RAM cycles and assembles or splits the data.
- MEM has fixed priority over IF, so a pending load/store never waits behind a new fetch.
- Sits between the pipeline stages and the top-level RAM interface.

---
 rtl/mem_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// mem_ctrl: shares one byte-wide RAM port between instruction fetch and the
// memory stage, turning 32-bit fetch/load/store requests into byte-serial
// RAM cycles. MEM has fixed priority over IF; every output is registered.
module mem_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_clear,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [1:0]        mem_len,
  input  logic [31:0]       mem_wdata,
  output logic              mem_done,
  output logic [31:0]       mem_rdata,
  input  logic [7:0]        ram_din,
  output logic [7:0]        ram_dout,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  // Architectural state
  state_t              state;
  logic [2:0]          cnt;      // byte index driven on ram_a this cycle
  logic [2:0]          nbytes;   // transfer length: 1, 2 or 4
  logic                owner_if; // current READ belongs to instruction fetch
  logic [ADDR_W-1:0]   addr;
  logic [31:0]         wdata;
  logic [31:0]         rbuf;     // assembly buffer, committed only on completion

  // Next-state values
  state_t              state_n;
  logic [2:0]          cnt_n, nbytes_n, cnt_inc;
  logic                owner_if_n;
  logic [ADDR_W-1:0]   addr_n, ram_a_n;
  logic [31:0]         wdata_n, rbuf_n, if_data_n, mem_rdata_n;
  logic [7:0]          ram_dout_n;
  logic                ram_wr_n, if_done_n, mem_done_n, busy_n;

  function automatic logic [7:0] byte_sel(input logic [31:0] d, input logic [1:0] i);
    return d[8*i +: 8];
  endfunction

  function automatic logic [2:0] len_to_n(input logic [1:0] len);
    case (len)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  assign cnt_inc = cnt + 3'd1;

  // Next-state and registered-output decode for the RAM sequencer
  always_comb begin
    // NOTE: every value assigned below gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    state_n     = state;
    cnt_n       = cnt;
    nbytes_n    = nbytes;
    owner_if_n  = owner_if;
    addr_n      = addr;
    wdata_n     = wdata;
    rbuf_n      = rbuf;
    if_data_n   = if_data;
    mem_rdata_n = mem_rdata;
    ram_a_n     = '0;
    ram_dout_n  = '0;
    ram_wr_n    = 1'b0;
    if_done_n   = 1'b0;
    mem_done_n  = 1'b0;

    unique case (state)
      IDLE: begin
        // A done pulse this cycle means the requester has not yet dropped
        // its req; skip one cycle so the stale request is not re-accepted.
        if (if_done || mem_done) begin
          state_n = IDLE;
        end else if (mem_req) begin
          owner_if_n = 1'b0;
          addr_n     = mem_addr;
          wdata_n    = mem_wdata;
          nbytes_n   = len_to_n(mem_len);
          cnt_n      = '0;
          rbuf_n     = '0;
          ram_a_n    = mem_addr;
          if (mem_we) begin
            state_n    = WRITE;
            ram_wr_n   = 1'b1;
            ram_dout_n = mem_wdata[7:0];
          end else begin
            state_n = READ;
          end
        end else if (if_req) begin
          state_n    = READ;
          owner_if_n = 1'b1;
          addr_n     = if_addr;
          nbytes_n   = 3'd4;
          cnt_n      = '0;
          rbuf_n     = '0;
          ram_a_n    = if_addr;
        end
      end

      READ: begin
        if (owner_if && if_clear) begin
          // Branch redirect: abandon the fetch, even on its final capture.
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_inc;
          if (cnt_inc < nbytes) ram_a_n = addr + ADDR_W'(cnt_inc);
          // Data for the address driven last cycle arrives now.
          case (cnt)
            3'd1:    rbuf_n[7:0]   = ram_din;
            3'd2:    rbuf_n[15:8]  = ram_din;
            3'd3:    rbuf_n[23:16] = ram_din;
            3'd4:    rbuf_n[31:24] = ram_din;
            default: ;
          endcase
          if (cnt == nbytes) begin
            state_n = IDLE;
            cnt_n   = '0;
            if (owner_if) begin
              if_data_n = rbuf_n;
              if_done_n = 1'b1;
            end else begin
              mem_rdata_n = rbuf_n;
              mem_done_n  = 1'b1;
            end
          end
        end
      end

      WRITE: begin
        if (cnt_inc < nbytes) begin
          cnt_n      = cnt_inc;
          ram_a_n    = addr + ADDR_W'(cnt_inc);
          ram_wr_n   = 1'b1;
          ram_dout_n = byte_sel(wdata, cnt_inc[1:0]);
        end else begin
          state_n    = IDLE;
          cnt_n      = '0;
          mem_done_n = 1'b1;
        end
      end

      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      nbytes    <= '0;
      owner_if  <= 1'b0;
      addr      <= '0;
      wdata     <= '0;
      rbuf      <= '0;
      if_data   <= '0;
      mem_rdata <= '0;
      ram_a     <= '0;
      ram_dout  <= '0;
      ram_wr    <= 1'b0;
      if_done   <= 1'b0;
      mem_done  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      nbytes    <= nbytes_n;
      owner_if  <= owner_if_n;
      addr      <= addr_n;
      wdata     <= wdata_n;
      rbuf      <= rbuf_n;
      if_data   <= if_data_n;
      mem_rdata <= mem_rdata_n;
      ram_a     <= ram_a_n;
      ram_dout  <= ram_dout_n;
      ram_wr    <= ram_wr_n;
      if_done   <= if_done_n;
      mem_done  <= mem_done_n;
      busy      <= busy_n;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed scenarios with literal expectations plus randomized
// IF/MEM traffic, all checked every cycle against a transaction-level model.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_clear, mem_req, mem_we;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic [1:0]  mem_len;
  logic        if_done, mem_done, ram_wr, busy;
  logic [31:0] if_data, mem_rdata, ram_a;
  logic [7:0]  ram_din, ram_dout;

  mem_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_clear(if_clear),
    .if_done(if_done), .if_data(if_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_len(mem_len),
    .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- RAM environment ----------------
  logic [7:0] ram    [logic [31:0]];
  logic [7:0] shadow [logic [31:0]];

  function automatic logic [7:0] dflt(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  function automatic logic [7:0] sh_rd(input logic [31:0] a);
    return shadow.exists(a) ? shadow[a] : dflt(a);
  endfunction

  task automatic preload(input logic [31:0] a, input logic [7:0] d);
    ram[a]    = d;
    shadow[a] = d;
  endtask

  initial begin
    ram_din = 8'h00;
    forever begin
      @(posedge clk);
      ram_din <= ram.exists(ram_a) ? ram[ram_a] : dflt(ram_a);
      if (ram_wr) ram[ram_a] = ram_dout;
    end
  end

  always @(posedge clk) cyc++;

  // ---------------- transaction-level model + per-cycle compare ----------------
  bit          m_valid = 0, m_active = 0, m_if_owner, m_we, m_zero = 0;
  logic [31:0] m_addr, m_wdata, m_rdata;
  int          m_n, m_t0;
  logic [31:0] e_if_data = '0, e_mem_rdata = '0;

  initial begin
    forever begin
      int          k;
      bit          e_ifd, e_md, e_busy, e_wr, chk_dout, done_now;
      logic [31:0] e_a, tmp;
      logic [7:0]  e_dout;
      @(negedge clk);
      k = cyc - m_t0;
      done_now = 0;
      if (m_valid) begin
        e_ifd = 0; e_md = 0; e_busy = 0; e_wr = 0; e_a = '0; e_dout = '0;
        chk_dout = m_zero;
        if (m_active) begin
          if (!m_we) begin
            if (k >= 1 && k <= m_n) e_a = m_addr + (k - 1);
            e_busy = (k >= 1 && k <= m_n + 1);
            if (k == m_n + 2) begin
              done_now = 1;
              if (m_if_owner) begin e_ifd = 1; e_if_data = m_rdata; end
              else begin e_md = 1; e_mem_rdata = m_rdata; end
            end
          end else begin
            if (k >= 1 && k <= m_n) begin
              e_a = m_addr + (k - 1);
              e_wr = 1;
              tmp = m_wdata >> (8 * (k - 1));
              e_dout = tmp[7:0];
              chk_dout = 1;
              shadow[e_a] = e_dout;
            end
            e_busy = (k >= 1 && k <= m_n);
            if (k == m_n + 1) begin done_now = 1; e_md = 1; end
          end
        end
        check("cyc_if_done",   if_done,   e_ifd);
        check("cyc_mem_done",  mem_done,  e_md);
        check("cyc_busy",      busy,      e_busy);
        check("cyc_ram_wr",    ram_wr,    e_wr);
        check("cyc_ram_a",     ram_a,     e_a);
        check("cyc_if_data",   if_data,   e_if_data);
        check("cyc_mem_rdata", mem_rdata, e_mem_rdata);
        if (chk_dout) check("cyc_ram_dout", ram_dout, e_dout);
      end

      // Effect of this cycle's inputs on the next cycle
      m_zero = 0;
      if (rst) begin
        m_active = 0; e_if_data = '0; e_mem_rdata = '0; m_zero = 1; m_valid = 1;
      end else if (m_valid) begin
        if (m_active && !m_we && m_if_owner && k >= 1 && k <= m_n + 1 && if_clear)
          m_active = 0;
        else if (done_now)
          m_active = 0;
        else if (!m_active && (mem_req || if_req)) begin
          m_active = 1;
          m_t0 = cyc;
          if (mem_req) begin
            m_if_owner = 0; m_we = mem_we; m_addr = mem_addr; m_wdata = mem_wdata;
            m_n = (mem_len == 2'd0) ? 1 : (mem_len == 2'd1) ? 2 : 4;
          end else begin
            m_if_owner = 1; m_we = 0; m_addr = if_addr; m_n = 4;
          end
          m_rdata = '0;
          if (!m_we)
            for (int i = 0; i < m_n; i++)
              m_rdata = m_rdata | (32'(sh_rd(m_addr + i)) << (8 * i));
        end
      end
    end
  end

  // ---------------- random traffic helpers ----------------
  function automatic logic [31:0] pick_addr();
    if ($urandom_range(0, 7) == 0) return 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
    return 32'h100 + 32'($urandom_range(0, 63));
  endfunction

  task automatic mem_driver();
    bit got;
    for (int t = 0; t < 60; t++) begin
      repeat ($urandom_range(1, 6)) step();
      mem_we    = 1'($urandom_range(0, 1));
      mem_len   = 2'($urandom_range(0, 3));
      mem_addr  = pick_addr();
      mem_wdata = $urandom;
      mem_req   = 1'b1;
      got = 0;
      for (int w = 0; w < 400 && !got; w++) begin
        step();
        if (mem_done) got = 1;
      end
      mem_req = 1'b0;
      check("mem_completes", got, 1);
    end
  endtask

  task automatic if_driver();
    bit got;
    for (int t = 0; t < 60; t++) begin
      repeat ($urandom_range(0, 5)) step();
      if_addr = pick_addr();
      if_req  = 1'b1;
      got = 0;
      for (int w = 0; w < 400 && !got; w++) begin
        step();
        if_clear = 1'b0;
        if (if_done) got = 1;
        else if ($urandom_range(0, 31) == 0) begin
          if_clear = 1'b1;
          if_addr  = pick_addr();
        end
      end
      if_req   = 1'b0;
      if_clear = 1'b0;
      check("if_completes", got, 1);
    end
  endtask

  // ---------------- directed scenarios + random phase ----------------
  initial begin
    int ifd, md;
    logic [7:0] st_b [4];
    st_b = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    rst = 1'b1; if_req = 0; if_clear = 0; if_addr = '0;
    mem_req = 0; mem_we = 0; mem_addr = '0; mem_len = '0; mem_wdata = '0;
    repeat (3) step();
    check("rst_busy", busy, 0);
    check("rst_ram_a", ram_a, 0);
    check("rst_if_data", if_data, 0);
    rst = 1'b0;
    step();

    // Word fetch from 0x1000
    preload(32'h1000, 8'h13); preload(32'h1001, 8'h05);
    preload(32'h1002, 8'h00); preload(32'h1003, 8'h00);
    if_addr = 32'h1000; if_req = 1;            // T0
    ifd = 0; md = 0;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k <= 4) check("t1_ram_a", ram_a, 32'h1000 + k - 1);
      if (k == 6) begin
        check("t1_if_done", if_done, 1);
        check("t1_if_data", if_data, 32'h0000_0513);
      end
      if (if_done) begin ifd++; if_req = 0; end
      if (mem_done) md++;
    end
    if_req = 0;
    check("t1_if_pulses", ifd, 1);
    check("t1_mem_pulses", md, 0);

    // Word store 0xDEADBEEF to 0x20
    mem_req = 1; mem_we = 1; mem_len = 2; mem_addr = 32'h20; mem_wdata = 32'hDEAD_BEEF;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k <= 4) begin
        check("t2_ram_wr", ram_wr, 1);
        check("t2_ram_a", ram_a, 32'h20 + k - 1);
        check("t2_ram_dout", ram_dout, st_b[k-1]);
      end
      if (k == 5) check("t2_mem_done", mem_done, 1);
      if (k == 6) check("t2_wr_off", ram_wr, 0);
      if (mem_done) mem_req = 0;
    end
    mem_req = 0; mem_we = 0;
    check("t2_ram_23", ram[32'h23], 8'hDE);

    // Half load from unaligned 0x31
    preload(32'h31, 8'h80); preload(32'h32, 8'hFF);
    step();
    mem_req = 1; mem_we = 0; mem_len = 1; mem_addr = 32'h31;
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k == 4) begin
        check("t3_mem_done", mem_done, 1);
        check("t3_mem_rdata", mem_rdata, 32'h0000_FF80);
      end
      if (mem_done) mem_req = 0;
    end
    mem_req = 0;

    // MEM byte load and IF fetch requested together
    preload(32'h40, 8'h7E);
    step();
    mem_req = 1; mem_we = 0; mem_len = 0; mem_addr = 32'h40;
    if_req = 1; if_addr = 32'h1000;
    ifd = 0; md = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 3) begin
        check("t4_mem_done", mem_done, 1);
        check("t4_mem_rdata", mem_rdata, 32'h0000_007E);
      end
      if (k == 5) check("t4_if_start", ram_a, 32'h1000);
      if (k == 10) begin
        check("t4_if_done", if_done, 1);
        check("t4_if_data", if_data, 32'h0000_0513);
      end
      if (mem_done) begin md++; mem_req = 0; end
      if (if_done) begin ifd++; if_req = 0; end
    end
    mem_req = 0; if_req = 0;
    check("t4_pulses", {ifd[15:0], md[15:0]}, {16'd1, 16'd1});

    // Fetch aborted by if_clear in T0+3, then a fresh fetch
    step();
    if_req = 1; if_addr = 32'h1000;
    ifd = 0;
    for (int k = 1; k <= 8; k++) begin
      step();
      if_clear = (k == 3);
      if (k == 3) if_req = 0;
      if (k == 4) check("t5_busy_off", busy, 0);
      if (if_done) ifd++;
    end
    if_clear = 0;
    check("t5_no_done", ifd, 0);
    preload(32'h2000, 8'h93); preload(32'h2001, 8'h00);
    preload(32'h2002, 8'h10); preload(32'h2003, 8'h00);
    if_req = 1; if_addr = 32'h2000;
    for (int k = 1; k <= 7; k++) begin
      step();
      if (k == 6) check("t5_refetch", if_data, 32'h0010_0093);
      if (if_done) if_req = 0;
    end
    if_req = 0;

    // Word store interrupted by reset taking effect at the start of T0+2
    for (int i = 0; i < 4; i++) preload(32'h50 + i, 8'h00);
    step();
    mem_req = 1; mem_we = 1; mem_len = 2; mem_addr = 32'h50; mem_wdata = 32'h1122_3344;
    step();                                    // T0+1
    rst = 1;
    step();                                    // T0+2
    rst = 0; mem_req = 0; mem_we = 0;
    check("t6_outs_zero",
          {31'(0), if_done} | {31'(0), mem_done} | if_data | mem_rdata | ram_a |
          {24'(0), ram_dout} | {31'(0), ram_wr} | {31'(0), busy}, 32'h0);
    md = 0;
    for (int k = 3; k <= 8; k++) begin
      step();
      if (mem_done) md++;
    end
    check("t6_no_done", md, 0);
    check("t6_byte0", ram[32'h50], 8'h44);
    check("t6_byte1", ram[32'h51], 8'h00);

    // Randomized concurrent traffic
    fork
      mem_driver();
      if_driver();
    join
    repeat (10) step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation watchdog expired");
  end

endmodule
